// File: rtl/led_breath_sequencer.sv
// Breathing LED sequencer: drives a shared up/down brightness counter
// and turns its level into per-channel PWM, all-together or chase.
module led_breath_sequencer #(
  parameter int NUM_LEDS  = 4,
  parameter int WIDTH     = 8,
  parameter int PRESCALE  = 1024,
  parameter int GAP_STEPS = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        chase,
  input  logic                        one_shot,
  input  logic [WIDTH-1:0]            cnt_q,
  output logic                        cnt_ena,
  output logic                        cnt_clr_n,
  output logic [NUM_LEDS-1:0]         led,
  output logic [$clog2(NUM_LEDS)-1:0] ch_idx,
  output logic                        busy,
  output logic                        done
);

  localparam int BREATH = 2 * ((1 << WIDTH) - 1);
  localparam int SMAX   = (BREATH > GAP_STEPS) ? BREATH : GAP_STEPS;
  localparam int PW     = $clog2(PRESCALE);
  localparam int SW     = $clog2(SMAX);
  localparam int CW     = $clog2(NUM_LEDS);

  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] FADE_LAST = SW'(BREATH - 1);
  localparam logic [SW-1:0] GAP_LAST  = SW'(GAP_STEPS - 1);
  localparam logic [CW-1:0] CH_LAST   = CW'(NUM_LEDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FADE,
    GAP
  } state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        pre_q, pre_d;
  logic [SW-1:0]        step_q, step_d;
  logic [CW-1:0]        ch_idx_q, ch_idx_d;
  logic                 chase_q, chase_d;
  logic                 one_shot_q, one_shot_d;
  logic [WIDTH-1:0]     pwm_q, pwm_d;
  logic [NUM_LEDS-1:0]  led_q, led_d;
  logic                 done_q, done_d;
  logic                 pre_wrap;
  logic                 pass_end;
  logic [NUM_LEDS-1:0]  en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pre_q      <= '0;
      step_q     <= '0;
      ch_idx_q   <= '0;
      chase_q    <= 1'b0;
      one_shot_q <= 1'b0;
      pwm_q      <= '0;
      led_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      step_q     <= step_d;
      ch_idx_q   <= ch_idx_d;
      chase_q    <= chase_d;
      one_shot_q <= one_shot_d;
      pwm_q      <= pwm_d;
      led_q      <= led_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    step_d     = step_q;
    ch_idx_d   = ch_idx_q;
    chase_d    = chase_q;
    one_shot_d = one_shot_q;
    done_d     = 1'b0;
    pwm_d      = pwm_q + 1'b1;
    pre_wrap   = (pre_q == PRE_LAST);
    pass_end   = !chase_q || (ch_idx_q == CH_LAST);

    unique case (state_q)
      IDLE: begin
        pre_d    = '0;
        step_d   = '0;
        ch_idx_d = '0;
        if (start) begin
          state_d    = FADE;
          chase_d    = chase;
          one_shot_d = one_shot;
        end
      end
      FADE: begin
        pre_d = pre_wrap ? '0 : pre_q + 1'b1;
        if (pre_wrap) begin
          if (step_q == FADE_LAST) begin
            step_d  = '0;
            state_d = GAP;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      GAP: begin
        pre_d = pre_wrap ? '0 : pre_q + 1'b1;
        if (pre_wrap) begin
          if (step_q == GAP_LAST) begin
            step_d = '0;
            if (one_shot_q && pass_end) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = FADE;
              if (chase_q)
                ch_idx_d = (ch_idx_q == CH_LAST) ? '0 : ch_idx_q + 1'b1;
            end
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (stop) begin
      state_d  = IDLE;
      done_d   = 1'b0;
      pre_d    = '0;
      step_d   = '0;
      ch_idx_d = '0;
    end

    for (int i = 0; i < NUM_LEDS; i++)
      en[i] = !chase_q || (ch_idx_q == CW'(i));
    // Gate on the next state so LEDs go dark on the same edge as GAP/stop.
    led_d = (state_d == FADE) ? (en & {NUM_LEDS{pwm_q < cnt_q}}) : '0;
  end

  assign cnt_ena   = (state_q == FADE) && pre_wrap;
  assign cnt_clr_n = (state_q == FADE);
  assign busy      = (state_q != IDLE);
  assign led       = led_q;
  assign ch_idx    = ch_idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_led_breath_sequencer.sv
// Directed bench for led_breath_sequencer with a behavioural
// up/down brightness counter attached to cnt_q.
module tb_led_breath_sequencer;

  localparam int N = 3;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         chase = 1'b0;
  logic         one_shot = 1'b0;
  logic [W-1:0] cnt_q;
  logic [W-1:0] ctr_q;
  logic [W-1:0] force_lvl = '0;
  logic         force_en = 1'b0;
  logic         up_q;
  logic         cnt_ena;
  logic         cnt_clr_n;
  logic [N-1:0] led;
  logic [1:0]   ch_idx;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;
  int pulses, fades, gaps, dones, first_pulse, peak, last_q;
  int led_bad, idx_seq, hi, k;
  logic [N-1:0] lit;
  bit timed_out;

  assign cnt_q = force_en ? force_lvl : ctr_q;

  led_breath_sequencer #(
    .NUM_LEDS (N),
    .WIDTH    (W),
    .PRESCALE (4),
    .GAP_STEPS(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .chase    (chase),
    .one_shot (one_shot),
    .cnt_q    (cnt_q),
    .cnt_ena  (cnt_ena),
    .cnt_clr_n(cnt_clr_n),
    .led      (led),
    .ch_idx   (ch_idx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge cnt_clr_n) begin
    if (!cnt_clr_n) begin
      ctr_q <= '0;
      up_q  <= 1'b1;
    end else if (cnt_ena) begin
      if (up_q) begin
        ctr_q <= ctr_q + 3'd1;
        if (ctr_q == 3'd6) up_q <= 1'b0;
      end else begin
        ctr_q <= ctr_q - 3'd1;
        if (ctr_q == 3'd1) up_q <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int budget, input int poke_at,
                     input int kind, input bit chase_exp);
    logic prev_clr = 1'b0;
    bit   poked = 1'b0;
    int   fc = 0;
    int   n = 0;
    pulses = 0; fades = 0; gaps = 0; dones = 0;
    first_pulse = -1; peak = 0; last_q = -1;
    led_bad = 0; idx_seq = 0; lit = '0; timed_out = 1'b1;
    while (n < budget) begin
      if (done) dones++;
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      if (cnt_clr_n && !prev_clr) begin
        fades++;
        idx_seq = idx_seq * 4 + int'(ch_idx);
        fc = 0;
      end
      if (cnt_clr_n) begin
        if (cnt_ena) begin
          pulses++;
          last_q = int'(cnt_q);
          if (first_pulse < 0) first_pulse = fc;
        end
        if (int'(cnt_q) > peak) peak = int'(cnt_q);
        fc++;
      end else begin
        gaps++;
        if (cnt_ena) led_bad++;
      end
      if (!cnt_clr_n && led != '0) led_bad++;
      if (chase_exp && ((led & ~(3'b001 << ch_idx)) != '0)) led_bad++;
      lit = lit | led;
      prev_clr = cnt_clr_n;
      if (!poked && kind != 0 && pulses == poke_at) begin
        poked = 1'b1;
        if (kind == 1) begin
          start = 1'b1;
          chase = ~chase;
          one_shot = ~one_shot;
        end else begin
          stop = 1'b1;
        end
      end
      tick();
      start = 1'b0;
      stop = 1'b0;
      n++;
    end
  endtask

  initial begin
    tick();
    tick();
    check("rst_led", int'(led), 0);
    check("rst_ena", int'(cnt_ena), 0);
    check("rst_clr_n", int'(cnt_clr_n), 0);
    check("rst_ch_idx", int'(ch_idx), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst_n = 1'b1;
    tick();

    chase = 1'b0; one_shot = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    run(200, 0, 0, 1'b0);
    check("t1_timeout", int'(timed_out), 0);
    check("t1_first_pulse", first_pulse, 3);
    check("t1_pulses", pulses, 14);
    check("t1_peak", peak, 7);
    check("t1_last_level", last_q, 1);
    check("t1_gap_cycles", gaps, 8);
    check("t1_dones", dones, 1);
    check("t1_lit", int'(lit), 7);
    check("t1_led_bad", led_bad, 0);
    check("t1_cnt_end", int'(cnt_q), 0);
    check("t1_busy_end", int'(busy), 0);

    chase = 1'b1; one_shot = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    run(500, 0, 0, 1'b1);
    check("t2_timeout", int'(timed_out), 0);
    check("t2_fades", fades, 3);
    check("t2_idx_seq", idx_seq, 6);
    check("t2_pulses", pulses, 42);
    check("t2_lit", int'(lit), 7);
    check("t2_led_bad", led_bad, 0);
    check("t2_dones", dones, 1);

    chase = 1'b1; one_shot = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    run(500, 19, 2, 1'b1);
    check("t4_timeout", int'(timed_out), 0);
    check("t4_pulses", pulses, 19);
    check("t4_busy", int'(busy), 0);
    check("t4_led", int'(led), 0);
    check("t4_clr_n", int'(cnt_clr_n), 0);
    check("t4_dones", dones, 0);
    hi = 0;
    repeat (6) begin
      hi += int'(done);
      tick();
    end
    check("t4_no_done", hi, 0);
    chase = 1'b1; one_shot = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_restart_busy", int'(busy), 1);
    check("t4_restart_idx", int'(ch_idx), 0);
    check("t4_restart_lvl", int'(cnt_q), 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t4_stop2_busy", int'(busy), 0);

    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("t5_start_stop_busy", int'(busy), 0);
    check("t5_start_stop_clr", int'(cnt_clr_n), 0);
    chase = 1'b1; one_shot = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    run(500, 2, 1, 1'b1);
    check("t5_timeout", int'(timed_out), 0);
    check("t5_fades", fades, 3);
    check("t5_pulses", pulses, 42);
    check("t5_idx_seq", idx_seq, 6);
    check("t5_led_bad", led_bad, 0);
    check("t5_dones", dones, 1);

    chase = 1'b0; one_shot = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    run(260, 0, 0, 1'b0);
    check("t6_still_busy", int'(timed_out), 1);
    check("t6_fades", fades, 5);
    check("t6_dones", dones, 0);
    force_en = 1'b1; force_lvl = 3'd4;
    tick();
    hi = 0;
    repeat (8) begin
      hi += int'(led[0]);
      tick();
    end
    check("t3_duty_4", hi, 4);
    force_lvl = 3'd0;
    tick();
    hi = 0;
    repeat (8) begin
      hi += int'(led != '0);
      tick();
    end
    check("t3_duty_0", hi, 0);
    check("t3_in_fade", int'(cnt_clr_n), 1);
    force_en = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;

    chase = 1'b1; one_shot = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!(ch_idx == 2'd1 && !cnt_clr_n) && k < 300) begin
      tick();
      k++;
    end
    check("t6_reach_gap", int'(k < 300), 1);
    tick();
    check("t6_gap_busy", int'(busy), 1);
    check("t6_gap_idx", int'(ch_idx), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_arst_busy", int'(busy), 0);
    check("t6_arst_idx", int'(ch_idx), 0);
    check("t6_arst_led", int'(led), 0);
    check("t6_arst_clr_n", int'(cnt_clr_n), 0);
    check("t6_arst_ena", int'(cnt_ena), 0);
    check("t6_arst_done", int'(done), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
